oqpsk_rcosine_demod: RTL and testbench
======================================

// Module: oqpsk_rcosine_demod
// PURPOSE
// - Receive-side counterpart of the OQPSK raised-cosine modulator: takes signed I/Q sample pairs and recovers the serial bit stream.
// - Per-rail integrate-and-dump detection, with the Q rail offset by half a symbol; each bit is decided by the sign of its rail sum.
// - Recovered bits come out in I0,Q0,I1,Q1,... order through a small FIFO with a valid/ready handshake.
// - Sits between the sample source (ADC/loopback) and the bit sink.
// PARAMETERS
// - DATA_W      13   width of signed I/Q samples (matches modulator output)
// - SPS         32   samples per rail symbol; even power of 2, >= 4
// - ACC_W       DATA_W+$clog2(SPS)   accumulator width; cannot overflow, no saturation
// - FIFO_DEPTH  4    output bit FIFO entries; power of 2
// PORTS
// - ACK           in   1       clock, rising edge
// - RST           in   1       async active-high reset
// - EN            in   1       demodulator enable; low = idle + flush
// - SAMPLE_VALID  in   1       I/Q pair valid this cycle
// - I             in   DATA_W  signed in-phase sample
// - Q             in   DATA_W  signed quadrature sample
// - Bit_Out       out  1       head-of-FIFO recovered bit
// - BIT_VALID     out  1       FIFO non-empty
// - BIT_READY     in   1       sink accepts Bit_Out when BIT_VALID=1
// - OVERRUN       out  1       sticky: a bit was dropped because the FIFO was full
// BEHAVIOUR
// - Clock/reset: one clock ACK; RST is asynchronous, active-high.
// - Reset: all outputs 0. State=IDLE. cnt=0. accI=accQ=0. FIFO empty.
// - A sample is "accepted" on an ACK edge with EN=1 && SAMPLE_VALID=1. SAMPLE_VALID=0 holds all state.
// - Sample counter: cnt (log2 SPS bits) increments per accepted sample and wraps SPS-1 -> 0.
// - FSM states: IDLE, PRIME, RUN.
//   - IDLE: on the first accepted sample -> PRIME. That sample is cnt=0 and is accumulated into accI.
//   - PRIME: covers cnt 0..SPS/2-1. I accumulates; Q is ignored. On the accepted sample with cnt==SPS/2-1 -> RUN.
//   - RUN: I and Q both accumulate each accepted sample.
//   - EN=0 in any state: next edge -> IDLE. Counter and accumulators cleared, FIFO flushed, OVERRUN cleared.
// - I dump: on the accepted sample with cnt==SPS-1.
//   - bitI = (accI + I >= 0) ? 1 : 0. Push bitI; accI <= 0.
// - Q dump (RUN only): on the accepted sample with cnt==SPS/2-1.
//   - Excluded: the PRIME->RUN transition sample.
//   - bitQ = (accQ + Q >= 0) ? 1 : 0. Push bitQ; accQ <= 0.
// - A sum of exactly 0 decides 1.
// - I and Q dumps never coincide, so there is at most one push per cycle.
// - Latency: the pushed bit is visible on Bit_Out/BIT_VALID the cycle after the dump edge, when the FIFO was empty.
// - Handshake: pop when BIT_VALID && BIT_READY.
//   - Bit_Out stays stable while BIT_VALID=1 and BIT_READY=0.
// - FIFO full and push without pop: the new bit is dropped and OVERRUN is set to 1.
// - FIFO full with push and pop in the same cycle: legal. Count unchanged, no overrun, order preserved.
// - FIFO empty with push and pop: no pop occurs (BIT_VALID was 0).
// - RST mid-symbol: immediate return to reset state. No partial bit is emitted.
// STRUCTURE
// - Shared package oqpsk_pkg:
//   - DATA_W, SPS defaults, shared with the modulator.
//   - FSM state encoding: IDLE=2'd0, PRIME=2'd1, RUN=2'd2.
// - Sub-module bit_fifo (WIDTH=1, DEPTH=FIFO_DEPTH).
//   - Synchronous push/pop, async reset, plus a flush input.
//   - Outputs: full, empty, head.
// - Top level holds the counter, FSM, two accumulators, decision logic and OVERRUN.
// TESTING
// - Reset: assert RST mid-run.
//   -> Bit_Out=0, BIT_VALID=0, OVERRUN=0 asynchronously; FSM=IDLE.
// - DC rails: I=+1000, Q=-1000, SAMPLE_VALID=1, BIT_READY=1, SPS=32.
//   -> first BIT_VALID the cycle after the 32nd sample; stream 1,0,1,0,...
//   -> Q bits spaced 32 samples apart, offset 16 from I bits.
// - Loopback: team's OQPSK modulator driven with bits 1,1,0,1,0,0,1,0.
//   -> identical 8 bits out, in order, with zero errors.
// - Backpressure: BIT_READY=0 for 6 dumps.
//   -> 4 bits held, OVERRUN=1 at the 5th dump; drain yields dumps 1-4 in order.
// - Full FIFO with push and pop on the same edge -> count stays 4, OVERRUN stays 0.
// - Boundary: one rail sums to exactly 0 -> bit 1.
// - EN drop mid-PRIME -> IDLE, no bit emitted; restart yields a correct first bit.

Source files
------------

// File: rtl/oqpsk_pkg.sv
// rtl/oqpsk_pkg.sv - shared OQPSK defaults and demodulator state encoding
package oqpsk_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int SPS_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } demod_state_e;

endpackage

// File: rtl/bit_fifo.sv
// rtl/bit_fifo.sv - small synchronous FIFO with flush, used for recovered bits
module bit_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop frees a slot on the same edge, so a full FIFO still takes a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/oqpsk_rcosine_demod.sv
// rtl/oqpsk_rcosine_demod.sv - OQPSK integrate-and-dump demodulator with bit FIFO
module oqpsk_rcosine_demod
  import oqpsk_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SPS        = SPS_DEF,
  parameter int ACC_W      = DATA_W + $clog2(SPS),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     ACK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     SAMPLE_VALID,
  input  logic signed [DATA_W-1:0] I,
  input  logic signed [DATA_W-1:0] Q,
  output logic                     Bit_Out,
  output logic                     BIT_VALID,
  input  logic                     BIT_READY,
  output logic                     OVERRUN
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SPS/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SPS - 1);

  demod_state_e            state;
  demod_state_e            state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic                    accept;
  logic                    dump_i;
  logic                    dump_q;
  logic                    push;
  logic                    push_bit;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_head;

  assign accept = EN && SAMPLE_VALID;
  assign sum_i  = acc_i + ACC_W'(I);
  assign sum_q  = acc_q + ACC_W'(Q);

  // Only RUN reaches cnt==SPS-1, and the PRIME->RUN sample is still in PRIME,
  // so that half-symbol boundary never produces a Q decision.
  assign dump_i = accept && (state == RUN) && (cnt == FULL_LAST);
  assign dump_q = accept && (state == RUN) && (cnt == HALF_LAST);

  assign push     = dump_i || dump_q;
  assign push_bit = dump_i ? ~sum_i[ACC_W-1] : ~sum_q[ACC_W-1];
  assign pop      = BIT_VALID && BIT_READY;

  assign BIT_VALID = !fifo_empty;
  assign Bit_Out   = fifo_head && !fifo_empty;

  always_comb begin
    state_nxt = state;
    if (!EN) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (cnt == HALF_LAST) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nxt;
      if (!EN) begin
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (accept) begin
        cnt   <= cnt + 1'b1;
        acc_i <= dump_i ? '0 : sum_i;
        if (state == RUN) begin
          acc_q <= dump_q ? '0 : sum_q;
        end
      end
    end
  end

  always_ff @(posedge ACK or posedge RST) begin
    if (RST) begin
      OVERRUN <= 1'b0;
    end else if (!EN) begin
      OVERRUN <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      OVERRUN <= 1'b1;
    end
  end

  bit_fifo #(
    .WIDTH (1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACK),
    .rst       (RST),
    .flush     (!EN),
    .push      (push),
    .push_data (push_bit),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_oqpsk_rcosine_demod.sv
// tb/tb_oqpsk_rcosine_demod.sv - directed self-checking bench for oqpsk_rcosine_demod
module tb_oqpsk_rcosine_demod;

  localparam int DW = 13;

  logic                 ACK = 1'b0;
  logic                 RST = 1'b1;
  logic                 EN = 1'b0;
  logic                 SAMPLE_VALID = 1'b0;
  logic                 BIT_READY = 1'b0;
  logic signed [DW-1:0] I = '0;
  logic signed [DW-1:0] Q = '0;
  logic                 Bit_Out;
  logic                 BIT_VALID;
  logic                 OVERRUN;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic got[$];
  int   got_cyc[$];
  int   pulse[32];
  logic lb_bits[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  oqpsk_rcosine_demod dut (
    .ACK          (ACK),
    .RST          (RST),
    .EN           (EN),
    .SAMPLE_VALID (SAMPLE_VALID),
    .I            (I),
    .Q            (Q),
    .Bit_Out      (Bit_Out),
    .BIT_VALID    (BIT_VALID),
    .BIT_READY    (BIT_READY),
    .OVERRUN      (OVERRUN)
  );

  always #5 ACK = ~ACK;

  // Records every bit actually handed to the sink.
  always @(posedge ACK) begin
    cyc <= cyc + 1;
    if (!RST && BIT_VALID && BIT_READY) begin
      got.push_back(Bit_Out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge ACK);
    @(negedge ACK);
  endtask

  task automatic samp(input int iv, input int qv);
    I = DW'(iv);
    Q = DW'(qv);
    SAMPLE_VALID = 1'b1;
    step();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) pulse[k] = 100 + 4 * k * (31 - k);
    repeat (2) @(negedge ACK);

    // reset state
    chk("rst_bit_out", Bit_Out, 1'b0);
    chk("rst_valid", BIT_VALID, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    chk_n("rst_state", int'(dut.state), 0);
    RST = 1'b0;
    EN = 1'b1;
    BIT_READY = 1'b1;

    // DC rails
    got.delete(); got_cyc.delete();
    for (int n = 1; n <= 31; n++) samp(1000, -1000);
    chk("dc_no_early_bit", BIT_VALID, 1'b0);
    samp(1000, -1000);
    chk("dc_first_valid", BIT_VALID, 1'b1);
    chk("dc_first_bit", Bit_Out, 1'b1);
    for (int n = 33; n <= 112; n++) samp(1000, -1000);
    SAMPLE_VALID = 1'b0;
    step();
    chk_n("dc_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk($sformatf("dc_bit%0d", i), got[i], (i % 2) == 0);
    if (got_cyc.size() >= 3) begin
      chk_n("dc_q_offset", got_cyc[1] - got_cyc[0], 16);
      chk_n("dc_i_spacing", got_cyc[2] - got_cyc[0], 32);
    end

    // reset mid-run with bits waiting
    EN = 1'b0; step(); EN = 1'b1;
    BIT_READY = 1'b0;
    for (int n = 1; n <= 48; n++) samp(1000, -1000);
    chk("mid_valid_before", BIT_VALID, 1'b1);
    SAMPLE_VALID = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_bit_out", Bit_Out, 1'b0);
    chk("mid_rst_valid", BIT_VALID, 1'b0);
    chk("mid_rst_overrun", OVERRUN, 1'b0);
    chk_n("mid_rst_state", int'(dut.state), 0);
    chk_n("mid_rst_cnt", int'(dut.cnt), 0);
    @(negedge ACK);
    RST = 1'b0;

    // backpressure: six dumps into a four-entry FIFO
    got.delete();
    for (int n = 1; n <= 80; n++) samp(1000, -1000);
    chk("bp_no_overrun_4", OVERRUN, 1'b0);
    chk_n("bp_count_4", int'(dut.u_fifo.count), 4);
    for (int n = 81; n <= 96; n++) samp(1000, -1000);
    chk("bp_overrun_5", OVERRUN, 1'b1);
    for (int n = 97; n <= 112; n++) samp(1000, -1000);
    SAMPLE_VALID = 1'b0;
    BIT_READY = 1'b1;
    repeat (6) step();
    chk_n("bp_drain_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("bp_bit%0d", i), got[i], (i % 2) == 0);
    chk("bp_overrun_sticky", OVERRUN, 1'b1);
    chk("bp_empty", BIT_VALID, 1'b0);

    // full FIFO with push and pop on the same edge
    EN = 1'b0; BIT_READY = 1'b0; step();
    chk("en_clears_overrun", OVERRUN, 1'b0);
    EN = 1'b1;
    for (int n = 1; n <= 95; n++) samp(1000, -1000);
    got.delete();
    BIT_READY = 1'b1;
    samp(1000, -1000);
    BIT_READY = 1'b0;
    chk_n("pp_count", int'(dut.u_fifo.count), 4);
    chk("pp_no_overrun", OVERRUN, 1'b0);
    chk_n("pp_popped", got.size(), 1);
    SAMPLE_VALID = 1'b0;
    BIT_READY = 1'b1;
    repeat (6) step();
    chk_n("pp_total", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk($sformatf("pp_bit%0d", i), got[i], (i % 2) == 0);

    // zero-sum rails decide 1; a sum of -1 decides 0
    EN = 1'b0; step(); EN = 1'b1;
    got.delete();
    for (int n = 1; n <= 64; n++) begin
      int iv;
      iv = (n % 2 == 1) ? 1000 : -1000;
      if (n == 64) iv = -1001;
      samp(iv, (n % 2 == 1) ? 7 : -7);
    end
    SAMPLE_VALID = 1'b0;
    step();
    chk_n("zero_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("zero_i_sum0", got[0], 1'b1);
      chk("zero_q_sum0", got[1], 1'b1);
      chk("zero_i_sum_m1", got[2], 1'b0);
    end

    // EN drop during PRIME, then a clean restart
    EN = 1'b0; step(); EN = 1'b1;
    for (int n = 1; n <= 10; n++) samp(-1000, 0);
    EN = 1'b0; SAMPLE_VALID = 1'b0; step();
    chk_n("endrop_state", int'(dut.state), 0);
    chk_n("endrop_cnt", int'(dut.cnt), 0);
    chk("endrop_no_bit", BIT_VALID, 1'b0);
    EN = 1'b1;
    for (int n = 1; n <= 31; n++) samp(200, 0);
    chk("restart_no_early", BIT_VALID, 1'b0);
    samp(200, 0);
    chk("restart_valid", BIT_VALID, 1'b1);
    chk("restart_bit", Bit_Out, 1'b1);

    // loopback of a shaped OQPSK waveform
    EN = 1'b0; SAMPLE_VALID = 1'b0; step(); EN = 1'b1;
    got.delete();
    for (int n = 0; n < 144; n++) begin
      int iv;
      int qv;
      iv = 0;
      qv = 0;
      if (n < 128) iv = lb_bits[2 * (n / 32)] ? pulse[n % 32] : -pulse[n % 32];
      if (n >= 16) qv = lb_bits[2 * ((n - 16) / 32) + 1] ? pulse[(n - 16) % 32] : -pulse[(n - 16) % 32];
      samp(iv, qv);
    end
    SAMPLE_VALID = 1'b0;
    step();
    chk_n("lb_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk($sformatf("lb_bit%0d", i), got[i], lb_bits[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
